// File: rtl/bram_serial_pkg.sv
// Shared types and constants for the serial block-RAM access controller.
// The state encoding and op-bit values are common to the controller and its bench.
package bram_serial_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RX_ADDR,
        RX_DATA,
        WRITE,
        READ_ADDR,
        READ_CAP,
        TX
    } state_t;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bram.sv
// Single-port synchronous block RAM: registered read data, one cycle after the address.
// The read returns the old word on a simultaneous write to the same address.
module bram #(
    parameter int MEMORY_DEPTH = 4096,
    parameter int DATA_WIDTH   = 16
) (
    input  logic                            clk,
    input  logic                            wr,
    input  logic [DATA_WIDTH-1:0]           data,
    input  logic [$clog2(MEMORY_DEPTH)-1:0] address,
    output logic [DATA_WIDTH-1:0]           q
);

    logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[address] <= data;
        end
        q <= mem[address];
    end

endmodule

// File: rtl/bram_serial_port.sv
// Serial-side access controller: deserialises op/address/data frames into block-RAM
// accesses and shifts read words back out MSB first.
module bram_serial_port
    import bram_serial_pkg::*;
#(
    parameter int MEMORY_DEPTH = 4096,
    parameter int DATA_WIDTH   = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            rx_valid,
    input  logic                            rx_bit,
    output logic                            tx_valid,
    output logic                            tx_bit,
    output logic                            busy,
    output logic                            mem_wr,
    output logic [DATA_WIDTH-1:0]           mem_data,
    output logic [$clog2(MEMORY_DEPTH)-1:0] mem_address,
    input  logic [DATA_WIDTH-1:0]           mem_q
);

    localparam int ADDRESS_WIDTH = $clog2(MEMORY_DEPTH);
    localparam int CNT_W         = $clog2(max_int(ADDRESS_WIDTH, DATA_WIDTH) + 1);

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDRESS_WIDTH - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

    state_t                  state;
    logic                    op;
    logic [CNT_W-1:0]        cnt;
    logic [DATA_WIDTH-1:0]   shreg;

    // Control path; the address and write-data registers double as shift registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op          <= OP_READ;
            cnt         <= '0;
            tx_valid    <= 1'b0;
            tx_bit      <= 1'b0;
            busy        <= 1'b0;
            mem_wr      <= 1'b0;
            mem_data    <= '0;
            mem_address <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        op    <= rx_bit;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RX_ADDR;
                    end
                end

                RX_ADDR: begin
                    if (rx_valid) begin
                        mem_address <= {mem_address[ADDRESS_WIDTH-2:0], rx_bit};
                        if (cnt == ADDR_LAST) begin
                            cnt   <= '0;
                            state <= (op == OP_WRITE) ? RX_DATA : READ_ADDR;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                RX_DATA: begin
                    if (rx_valid) begin
                        mem_data <= {mem_data[DATA_WIDTH-2:0], rx_bit};
                        if (cnt == DATA_LAST) begin
                            cnt    <= '0;
                            mem_wr <= 1'b1;
                            state  <= WRITE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                WRITE: begin
                    mem_wr <= 1'b0;
                    cnt    <= '0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end

                READ_ADDR: begin
                    cnt   <= '0;
                    state <= READ_CAP;
                end

                READ_CAP: begin
                    tx_valid <= 1'b1;
                    tx_bit   <= mem_q[DATA_WIDTH-1];
                    cnt      <= '0;
                    state    <= TX;
                end

                TX: begin
                    if (cnt == DATA_LAST) begin
                        tx_valid <= 1'b0;
                        tx_bit   <= 1'b0;
                        cnt      <= '0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        tx_bit <= shreg[DATA_WIDTH-2];
                        cnt    <= cnt + 1'b1;
                    end
                end

                default: begin
                    tx_valid <= 1'b0;
                    tx_bit   <= 1'b0;
                    mem_wr   <= 1'b0;
                    cnt      <= '0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    // Read-data shift register; its MSB always mirrors the bit currently on tx_bit
    always_ff @(posedge clk) begin
        if (state == READ_CAP) begin
            shreg <= mem_q;
        end else if (state == TX) begin
            shreg <= shreg << 1;
        end
    end

endmodule

// File: tb/tb_bram_serial_port.sv
// Directed bench for bram_serial_port with an attached bram; read words are scored
// against a shadow memory through an expected-value queue.
module tb_bram_serial_port;

    localparam int MEMORY_DEPTH = 4096;
    localparam int DATA_WIDTH   = 16;
    localparam int AW           = 12;

    logic                  clk;
    logic                  rst;
    logic                  rx_valid;
    logic                  rx_bit;
    logic                  tx_valid;
    logic                  tx_bit;
    logic                  busy;
    logic                  mem_wr;
    logic [DATA_WIDTH-1:0] mem_data;
    logic [AW-1:0]         mem_address;
    logic [DATA_WIDTH-1:0] mem_q;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_cnt = 0;

    logic [DATA_WIDTH-1:0] model [MEMORY_DEPTH];
    logic [DATA_WIDTH-1:0] exp_q [$];

    bram_serial_port #(
        .MEMORY_DEPTH(MEMORY_DEPTH),
        .DATA_WIDTH  (DATA_WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_valid   (rx_valid),
        .rx_bit     (rx_bit),
        .tx_valid   (tx_valid),
        .tx_bit     (tx_bit),
        .busy       (busy),
        .mem_wr     (mem_wr),
        .mem_data   (mem_data),
        .mem_address(mem_address),
        .mem_q      (mem_q)
    );

    bram #(
        .MEMORY_DEPTH(MEMORY_DEPTH),
        .DATA_WIDTH  (DATA_WIDTH)
    ) ram (
        .clk    (clk),
        .wr     (mem_wr),
        .data   (mem_data),
        .address(mem_address),
        .q      (mem_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_wr === 1'b1) wr_cnt <= wr_cnt + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (observed timeout, expected finish)");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives the first n bits of {op, addr, data}, one per rx_valid cycle, with optional gaps
    task automatic send_bits(input logic op, input logic [AW-1:0] addr,
                             input logic [DATA_WIDTH-1:0] data, input int n, input int max_gap);
        logic [28:0] f;
        f = {op, addr, data};
        for (int i = 0; i < n; i++) begin
            if (max_gap > 0) begin
                repeat ($urandom_range(0, max_gap)) begin
                    rx_valid = 1'b0;
                    @(negedge clk);
                end
            end
            rx_valid = 1'b1;
            rx_bit   = f[28-i];
            @(negedge clk);
        end
        rx_valid = 1'b0;
        rx_bit   = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] addr, input logic [DATA_WIDTH-1:0] data,
                            input int max_gap);
        int w0;
        w0 = wr_cnt;
        send_bits(1'b1, addr, data, 29, max_gap);
        model[addr] = data;
        chk("wr_pulse", mem_wr, 1);
        chk("wr_addr", mem_address, addr);
        chk("wr_data", mem_data, data);
        @(negedge clk);
        chk("wr_pulse_end", mem_wr, 0);
        chk("wr_busy_low", busy, 0);
        chk("wr_count", wr_cnt - w0, 1);
    endtask

    // Called on the first TX cycle; samples DATA_WIDTH consecutive bits
    task automatic collect_tx(input bit noisy, output logic [DATA_WIDTH-1:0] w);
        w = '0;
        for (int k = 0; k < DATA_WIDTH; k++) begin
            chk("tx_valid_run", tx_valid, 1);
            w = {w[DATA_WIDTH-2:0], tx_bit};
            if (noisy) begin
                rx_valid = 1'($urandom_range(0, 1));
                rx_bit   = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
        end
        rx_valid = 1'b0;
        rx_bit   = 1'b0;
        chk("tx_done_valid", tx_valid, 0);
        chk("tx_done_busy", busy, 0);
    endtask

    task automatic do_read(input logic [AW-1:0] addr, input int max_gap, input bit noisy);
        logic [DATA_WIDTH-1:0] w;
        logic [DATA_WIDTH-1:0] e;
        int w0;
        w0 = wr_cnt;
        exp_q.push_back(model[addr]);
        send_bits(1'b0, addr, '0, 13, max_gap);
        chk("rd_lat_n1", tx_valid, 0);
        chk("rd_busy", busy, 1);
        @(negedge clk);
        chk("rd_lat_n2", tx_valid, 0);
        @(negedge clk);
        collect_tx(noisy, w);
        e = exp_q.pop_front();
        chk("rd_word", w, e);
        chk("rd_no_wr", wr_cnt - w0, 0);
    endtask

    initial begin
        int w0;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_bit   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_bit", tx_bit, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_data", mem_data, 0);
        chk("rst_mem_addr", mem_address, 0);
        @(negedge clk);

        // Test 1 and 2: basic write then read, MSB-first stream
        do_write(12'h0A5, 16'hBEEF, 0);
        @(negedge clk);
        do_read(12'h0A5, 0, 0);

        // Test 3: address extremes with random rx_valid gaps
        do_write(12'hFFF, 16'h1234, 3);
        do_write(12'h000, 16'h5678, 3);
        do_read(12'hFFF, 3, 0);
        do_read(12'h000, 3, 0);

        // Test 4: rx_valid noise during TX is ignored, next frame decodes
        do_read(12'h0A5, 0, 1);
        do_read(12'hFFF, 0, 0);

        // Test 5a: reset after the 10th data bit, coincident with an rx bit
        do_write(12'h010, 16'hA5A5, 0);
        w0 = wr_cnt;
        send_bits(1'b1, 12'h010, 16'h1111, 23, 0);
        rst      = 1'b1;
        rx_valid = 1'b1;
        rx_bit   = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        rx_valid = 1'b0;
        rx_bit   = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_tx_valid", tx_valid, 0);
        chk("abort_mem_wr", mem_wr, 0);
        chk("abort_mem_data", mem_data, 0);
        chk("abort_mem_addr", mem_address, 0);
        repeat (3) @(negedge clk);
        chk("abort_no_wr", wr_cnt - w0, 0);
        chk("abort_still_idle", busy, 0);
        do_read(12'h010, 0, 0);

        // Test 5b: reset at the 5th TX bit
        send_bits(1'b0, 12'h010, '0, 13, 0);
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("abort_tx_pre", tx_valid, 1);
            if (k < 4) @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("txabort_valid", tx_valid, 0);
        chk("txabort_busy", busy, 0);
        chk("txabort_bit", tx_bit, 0);
        @(negedge clk);
        chk("txabort_valid_hold", tx_valid, 0);
        do_read(12'h010, 0, 0);

        // Test 6: back-to-back frames starting the cycle busy falls
        do_write(12'h123, 16'hCAFE, 0);
        do_read(12'h123, 0, 0);
        do_read(12'h0A5, 0, 0);
        do_write(12'h7E1, 16'h8001, 1);
        do_read(12'h7E1, 0, 0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
